// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART TX serialiser (start, LSB-first data, optional parity, 1/2 stop); TX_BREAK_EN adds break_req and a BREAK state
module uart_tx_framer #(
  parameter int DATA_WIDTH   = 7,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
`ifdef TX_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  data_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2) begin : g_bad_param
    $error("uart_tx_framer: illegal parameter value");
  end
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef TX_BREAK_EN
    , S_BREAK, S_BSTOP
`endif
  } state_t;
  state_t                r_state, w_next;
  logic [BW-1:0]         r_baud;
  logic [3:0]            r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  w_tick, w_last_bit, w_last_stop, w_load;
  assign w_tick      = r_baud == BW'(CLKS_PER_BIT - 1);
  assign w_last_bit  = r_bit == 4'(DATA_WIDTH - 1);
  assign w_last_stop = r_bit == 4'(STOP_BITS - 1);
  assign data_ready  = r_state == S_IDLE;
  assign busy        = r_state != S_IDLE;
  assign frame_done  = r_state == S_STOP && w_tick && w_last_stop;
  assign tx = r_state == S_START  ? 1'b0 :
              r_state == S_DATA   ? r_shift[0] :
              r_state == S_PARITY ? r_par :
`ifdef TX_BREAK_EN
              r_state == S_BREAK  ? 1'b0 :
`endif
              1'b1;
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef TX_BREAK_EN
        if (break_req) w_next = S_BREAK;
        else
`endif
        if (data_valid) begin
          w_next = S_START;
          w_load = 1'b1;
        end
      end
      S_START:  w_next = w_tick ? S_DATA : S_START;
      S_DATA:   w_next = (w_tick && w_last_bit) ? (PARITY_MODE != 0 ? S_PARITY : S_STOP) : S_DATA;
      S_PARITY: w_next = w_tick ? S_STOP : S_PARITY;
      S_STOP:   w_next = (w_tick && w_last_stop) ? S_IDLE : S_STOP;
`ifdef TX_BREAK_EN
      S_BREAK:  w_next = break_req ? S_BREAK : S_BSTOP;
      S_BSTOP:  w_next = (w_tick && w_last_stop) ? S_IDLE : S_BSTOP;
`endif
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_baud  <= (r_state == S_IDLE || w_tick
`ifdef TX_BREAK_EN
                  || r_state == S_BREAK
`endif
                 ) ? '0 : r_baud + 1'b1;
      r_bit   <= (w_next != r_state) ? '0 : r_bit + 4'(w_tick);
      if (w_load) begin
        r_shift <= data_in;
        r_par   <= PARITY_MODE == 1 ? ~^data_in : ^data_in;
      end else if (r_state == S_DATA && w_tick) begin
        r_shift <= r_shift >> 1;
      end
    end
  end
endmodule
